ifetch: RTL

IFETCH -- requirements
Module: ifetch

---
 rtl/rv32i_pkg.sv | 17 +
 rtl/fetch_buf.sv | 66 ++++++
 rtl/ifetch.sv | 107 ++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared fetch-path types: FSM state encoding, the buffered {instr, pc} entry and the instruction size.
package rv32i_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {instr, pc} FIFO. A push is visible at the head one cycle later.
// Flush wins over push/pop. A push into a full buffer is refused unless it coincides with a pop.
module fetch_buf
  import rv32i_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_dat_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push && !do_pop)      count_d = count_q + 2'd1;
      else if (do_pop && !do_push) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is reset so the head reads as zero while the block is held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding imem request, responses buffered 2-deep, 1-cycle response-to-instr_valid.
// Requests stall while the buffer is full; a redirect flushes the buffer and drops any in-flight response.
module ifetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         buf_push;
  fetch_entry_t buf_push_dat;
  fetch_entry_t buf_head;
  logic [1:0]   buf_count;
  logic         req_hs;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Gated by rst_n so no request is presented while the memory side is also held in reset.
  assign imem_req_valid = rst_n && (state_q == S_REQ) && (buf_count != 2'd2);
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign buf_push_dat.instr = imem_rsp_data;
  assign buf_push_dat.pc    = inflight_pc_q;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    buf_push      = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      // A request already on the wire (or accepted this cycle) still owes a response that must be swallowed.
      case (state_q)
        S_REQ:   state_d = req_hs ? S_DROP : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_hs) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'(INSTR_BYTES);
            state_d       = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            buf_push = 1'b1;
            state_d  = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (buf_push),
    .push_dat_i (buf_push_dat),
    .pop_i      (instr_valid && instr_ready),
    .flush_i    (redirect_valid),
    .head_dat_o (buf_head),
    .count_o    (buf_count)
  );

  assign instr_valid = (buf_count != 2'd0);
  assign instr       = buf_head.instr;
  assign instr_pc    = buf_head.pc;

endmodule
